// File: rtl/uart_rx_tx_bridge.sv
// Loopback bridge between uart_rx and uart_tx: rising-edge rx strobes fill a FIFO that is
// drained one byte per tx_start/tx_done handshake, guarded by a tx completion watchdog.
module uart_rx_tx_bridge #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned TX_TIMEOUT = 4096
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   rx_data,
  input  logic                rx_done,
  input  logic                tx_done,
  output logic [DATA_W-1:0]   tx_data,
  output logic                tx_start,
  output logic [DEPTH_LOG2:0] fifo_count,
  output logic                fifo_empty,
  output logic                fifo_full,
  output logic                overflow,
  output logic                tx_err,
  input  logic                err_clr
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned TMO_W = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT) : 1;
  localparam logic [DEPTH_LOG2:0]   FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   CNT_ZERO = {(DEPTH_LOG2+1){1'b0}};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
  localparam logic [TMO_W-1:0]      TMO_ONE  = {{(TMO_W-1){1'b0}}, 1'b1};
  localparam logic [TMO_W-1:0]      TMO_LAST = TMO_W'(TX_TIMEOUT - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [DATA_W-1:0]     tx_data_q, tx_data_d;
  logic                  tx_start_q, tx_start_d;
  logic                  empty_q, empty_d;
  logic                  full_q, full_d;
  logic                  overflow_q, overflow_d;
  logic                  tx_err_q, tx_err_d;
  logic                  rx_done_q, tx_done_q;
  logic [DATA_W-1:0]     mem [DEPTH];

  logic wr_ev, tx_edge, pop, tmo_hit, wr_ok, drop;

  assign wr_ev   = rx_done & ~rx_done_q;
  assign tx_edge = tx_done & ~tx_done_q;

  // Handshake FSM: pop from IDLE, then wait for the tx_done edge or the watchdog.
  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    pop     = 1'b0;
    tmo_hit = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tmo_d = {TMO_W{1'b0}};
        if (count_q != CNT_ZERO) begin
          pop     = 1'b1;
          state_d = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (tx_edge) begin
          state_d = ST_IDLE;
          tmo_d   = {TMO_W{1'b0}};
        end else if (tmo_q == TMO_LAST) begin
          tmo_hit = 1'b1;
          state_d = ST_IDLE;
          tmo_d   = {TMO_W{1'b0}};
        end else begin
          tmo_d = tmo_q + TMO_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tmo_d   = {TMO_W{1'b0}};
      end
    endcase
  end

  // FIFO bookkeeping; a pop at full frees the slot the concurrent write lands in.
  always_comb begin
    wr_ok      = wr_ev & ((count_q != FULL_CNT) | pop);
    drop       = wr_ev & (count_q == FULL_CNT) & ~pop;
    wr_ptr_d   = wr_ok ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d   = pop ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    count_d    = count_q + {{DEPTH_LOG2{1'b0}}, wr_ok} - {{DEPTH_LOG2{1'b0}}, pop};
    tx_data_d  = pop ? mem[rd_ptr_q] : tx_data_q;
    tx_start_d = pop;
    empty_d    = (count_d == CNT_ZERO);
    full_d     = (count_d == FULL_CNT);
    if (drop) begin
      overflow_d = 1'b1;
    end else if (err_clr) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
    if (tmo_hit) begin
      tx_err_d = 1'b1;
    end else if (err_clr) begin
      tx_err_d = 1'b0;
    end else begin
      tx_err_d = tx_err_q;
    end
  end

  // State registers; edge detectors reset high so a strobe held through reset is not an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tmo_q      <= {TMO_W{1'b0}};
      wr_ptr_q   <= {DEPTH_LOG2{1'b0}};
      rd_ptr_q   <= {DEPTH_LOG2{1'b0}};
      count_q    <= CNT_ZERO;
      tx_data_q  <= {DATA_W{1'b0}};
      tx_start_q <= 1'b0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
      tx_err_q   <= 1'b0;
      rx_done_q  <= 1'b1;
      tx_done_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      tmo_q      <= tmo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
      tx_err_q   <= tx_err_d;
      rx_done_q  <= rx_done;
      tx_done_q  <= tx_done;
    end
  end

  // Byte storage; contents need no reset since occupancy lives in the pointers.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr_q] <= rx_data;
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_start   = tx_start_q;
  assign fifo_count = count_q;
  assign fifo_empty = empty_q;
  assign fifo_full  = full_q;
  assign overflow   = overflow_q;
  assign tx_err     = tx_err_q;

endmodule

// File: tb/tb_uart_rx_tx_bridge.sv
// Self-checking bench for uart_rx_tx_bridge: cycle table for a single byte, then
// scoreboard-checked bursts, overflow/wrap, write+pop at full, watchdog and reset cases.
module tb_uart_rx_tx_bridge;

  localparam int DATA_W     = 8;
  localparam int DEPTH_LOG2 = 4;
  localparam int TX_TIMEOUT = 4096;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [DATA_W-1:0]   rx_data = 8'h00;
  logic                rx_done = 1'b0;
  logic                tx_done = 1'b0;
  logic                err_clr = 1'b0;
  logic [DATA_W-1:0]   tx_data;
  logic                tx_start;
  logic [DEPTH_LOG2:0] fifo_count;
  logic                fifo_empty;
  logic                fifo_full;
  logic                overflow;
  logic                tx_err;

  uart_rx_tx_bridge #(
    .DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2), .TX_TIMEOUT(TX_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done), .tx_done(tx_done),
    .tx_data(tx_data), .tx_start(tx_start), .fifo_count(fifo_count),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full), .overflow(overflow),
    .tx_err(tx_err), .err_clr(err_clr)
  );

  always #42 clk = ~clk;

  typedef struct {
    logic       rx_done;
    logic [7:0] rx_data;
    logic       tx_done;
    logic       exp_start;
    logic [4:0] exp_count;
    logic       exp_empty;
    logic [7:0] exp_data;
  } vec_t;

  int         total = 0;
  int         bad = 0;
  int         starts = 0;
  int         cyc = 0;
  int         last_start_cyc = 0;
  logic       prev_start = 1'b0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock; sample just after the edge and score any tx_start against the queue.
  task automatic tick();
    logic [7:0] e;
    @(posedge clk);
    #1;
    cyc++;
    if (tx_start === 1'b1) begin
      starts++;
      last_start_cyc = cyc;
      check("tx_start_width", {31'd0, prev_start}, 32'd0);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_tx_start: got tx_data %0h with no byte expected", tx_data);
      end else begin
        e = exp_q.pop_front();
        check("tx_data_order", {24'd0, tx_data}, {24'd0, e});
      end
    end
    prev_start = tx_start;
  endtask

  task automatic rx_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    tick();
  endtask

  task automatic drain_one(input string name);
    int s0;
    s0 = starts;
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    for (int i = 0; i < 8 && starts == s0; i++) tick();
    check(name, starts, s0 + 1);
  endtask

  initial begin
    #(84 * 60000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    vec_t vecs[8];
    int   peak;
    int   s0;
    int   c0;
    int   n;

    vecs[0] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b1, 8'h00};
    vecs[1] = '{1'b1, 8'hAA, 1'b0, 1'b0, 5'd1, 1'b0, 8'h00};
    vecs[2] = '{1'b1, 8'hAA, 1'b0, 1'b1, 5'd0, 1'b1, 8'hAA};
    vecs[3] = '{1'b1, 8'hAA, 1'b0, 1'b0, 5'd0, 1'b1, 8'hAA};
    vecs[4] = '{1'b0, 8'hAA, 1'b0, 1'b0, 5'd0, 1'b1, 8'hAA};
    vecs[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b1, 8'hAA};
    vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b1, 8'hAA};
    vecs[7] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b1, 8'hAA};

    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_start", {31'd0, tx_start}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("rst_count", {27'd0, fifo_count}, 32'd0);
    check("rst_empty", {31'd0, fifo_empty}, 32'd1);
    check("rst_full", {31'd0, fifo_full}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_tx_err", {31'd0, tx_err}, 32'd0);
    #20;
    rst = 1'b0;

    // Single byte, cycle by cycle.
    exp_q.push_back(8'hAA);
    for (int i = 0; i < 8; i++) begin
      rx_done = vecs[i].rx_done;
      rx_data = vecs[i].rx_data;
      tx_done = vecs[i].tx_done;
      tick();
      check($sformatf("vec%0d_start", i), {31'd0, tx_start}, {31'd0, vecs[i].exp_start});
      check($sformatf("vec%0d_count", i), {27'd0, fifo_count}, {27'd0, vecs[i].exp_count});
      check($sformatf("vec%0d_empty", i), {31'd0, fifo_empty}, {31'd0, vecs[i].exp_empty});
      check($sformatf("vec%0d_data", i), {24'd0, tx_data}, {24'd0, vecs[i].exp_data});
    end
    check("single_start_count", starts, 1);

    // Blocker byte keeps the FSM in WAIT so the burst accumulates.
    exp_q.push_back(8'h5A);
    rx_byte(8'h5A);
    peak = 0;
    for (int i = 1; i <= 5; i++) begin
      exp_q.push_back(8'(i));
      rx_byte(8'(i));
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
    end
    check("burst_peak", peak, 5);
    for (int i = 0; i < 5; i++) drain_one("burst_drain");
    check("burst_count_end", {27'd0, fifo_count}, 32'd0);
    check("burst_starts", starts, 7);

    // Overflow: 17 writes while the FSM waits on 8'h05.
    for (int i = 0; i < 17; i++) begin
      if (i < 16) exp_q.push_back(8'h10 + 8'(i));
      rx_byte(8'h10 + 8'(i));
      if (i == 15) begin
        check("ovf_full16", {31'd0, fifo_full}, 32'd1);
        check("ovf_count16", {27'd0, fifo_count}, 32'd16);
        check("ovf_flag16", {31'd0, overflow}, 32'd0);
      end
    end
    check("ovf_count17", {27'd0, fifo_count}, 32'd16);
    check("ovf_flag17", {31'd0, overflow}, 32'd1);
    for (int i = 0; i < 16; i++) drain_one("ovf_drain");
    check("ovf_drained_empty", {31'd0, fifo_empty}, 32'd1);
    check("ovf_sticky", {31'd0, overflow}, 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("ovf_cleared", {31'd0, overflow}, 32'd0);

    // Second fill wraps the pointers again.
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(8'h30 + 8'(i));
      rx_byte(8'h30 + 8'(i));
    end
    check("wrap_full", {31'd0, fifo_full}, 32'd1);

    // Write coinciding with the pop at full.
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    rx_data = 8'h40;
    rx_done = 1'b1;
    exp_q.push_back(8'h40);
    tick();
    check("simul_start", {31'd0, tx_start}, 32'd1);
    check("simul_count", {27'd0, fifo_count}, 32'd16);
    check("simul_full", {31'd0, fifo_full}, 32'd1);
    check("simul_overflow", {31'd0, overflow}, 32'd0);
    rx_done = 1'b0;
    tick();
    for (int i = 0; i < 16; i++) drain_one("simul_drain");
    check("simul_queue_empty", exp_q.size(), 0);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    tick();
    check("idle_count", {27'd0, fifo_count}, 32'd0);

    // Watchdog: tx_done never arrives.
    exp_q.push_back(8'h77);
    rx_byte(8'h77);
    c0 = last_start_cyc;
    n = 0;
    while (tx_err !== 1'b1 && n < TX_TIMEOUT + 200) begin
      tick();
      n++;
    end
    check("tmo_latency", cyc - c0, TX_TIMEOUT);
    check("tmo_err", {31'd0, tx_err}, 32'd1);
    s0 = starts;
    exp_q.push_back(8'h78);
    rx_byte(8'h78);
    check("tmo_next_pop", starts, s0 + 1);
    check("tmo_err_sticky", {31'd0, tx_err}, 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("tmo_err_cleared", {31'd0, tx_err}, 32'd0);

    // Async reset mid-WAIT with 3 bytes queued; rx_done held across release.
    rx_byte(8'hA1);
    rx_byte(8'hA2);
    rx_byte(8'hA3);
    check("rstmid_count3", {27'd0, fifo_count}, 32'd3);
    @(posedge clk);
    #30;
    rst = 1'b1;
    rx_done = 1'b1;
    rx_data = 8'hEE;
    #1;
    check("rstmid_start", {31'd0, tx_start}, 32'd0);
    check("rstmid_count", {27'd0, fifo_count}, 32'd0);
    check("rstmid_empty", {31'd0, fifo_empty}, 32'd1);
    #20;
    rst = 1'b0;
    s0 = starts;
    repeat (6) tick();
    check("rstmid_no_replay", starts, s0);
    check("rstmid_no_write", {27'd0, fifo_count}, 32'd0);
    rx_done = 1'b0;
    tick();
    exp_q.push_back(8'hC3);
    rx_byte(8'hC3);
    check("rstmid_new_byte", starts, s0 + 1);
    check("final_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
